arr_check_sequencer: RTL and testbench
======================================

// Module: arr_check_sequencer
// PURPOSE
// - Upstream stimulus stage for the arr checker instances: walks NUM_PATTERNS
//   test patterns onto sig/rfr and strobes check once per pattern.
// - Shadows the arr compare (sig != rfr at check) and counts mismatches, so a
//   failure is visible to the bench or VPI without relying on $stop.
// - One instance per arr instance; LENGTH matches the arr it feeds.
// PARAMETERS
// - LENGTH        1  width of sig/rfr; equals the downstream arr LENGTH.
// - NUM_PATTERNS  8  patterns per run (>=1).
// - CHECK_GAP     2  idle cycles after each check pulse (>=0).
// - IDX_W         $clog2(NUM_PATTERNS), min 1; width of pattern_idx.
// PORTS
// - clk           in   1       clock, all logic on posedge.
// - rst_n         in   1       asynchronous active-low reset.
// - start         in   1       begin a run; sampled only in IDLE.
// - inject_err    in   1       corrupt rfr bit 0 of the next loaded pattern.
// - sig           out  LENGTH  pattern value to arr.sig.
// - rfr           out  LENGTH  reference value to arr.rfr.
// - check         out  1       one-cycle compare strobe to arr.check.
// - busy          out  1       high from LOAD through last GAP.
// - done          out  1       one-cycle pulse at end of run.
// - pattern_idx   out  IDX_W   index of the pattern currently on sig.
// - mismatch_cnt  out  8       mismatches this run, saturates at 255.
// BEHAVIOUR
// - Reset (async assert, sync deassert via clk): state IDLE. All outputs 0.
//   err_pend is 0.
// - FSM: IDLE -> LOAD -> CHECK -> GAP (CHECK_GAP cycles) -> LOAD | DONE -> IDLE.
//   - IDLE: start=1 -> LOAD. This edge clears mismatch_cnt and pattern_idx.
//   - LOAD (1 cycle): at its closing edge, sig <= pattern(k).
//     rfr <= pattern(k) ^ {{LENGTH-1{0}}, (err_pend | inject_err)}.
//     err_pend clears on the same edge.
//   - CHECK (1 cycle): check=1. If sig != rfr, mismatch_cnt += 1,
//     saturating at 255.
//   - GAP: check=0, sig/rfr held. CHECK_GAP=0 skips GAP entirely.
//   - After the last cycle of the pattern, k == NUM_PATTERNS-1 -> DONE.
//     Otherwise pattern_idx += 1 -> LOAD.
//   - DONE (1 cycle): done=1, busy=0 -> IDLE.
// - pattern(k) = k zero-extended or truncated to LENGTH bits.
//   Bit 0 always toggles between consecutive patterns.
// - err_pend sets on any edge with inject_err=1, except the LOAD closing edge,
//   where inject_err is consumed directly.
//   - Multiple requests before a LOAD corrupt only one pattern.
//   - inject_err in IDLE carries over into the first pattern of the next run.
// - busy=1 in LOAD/CHECK/GAP. start is ignored while busy or in DONE.
// - Latency: start accepted on edge E0 -> LOAD in cycle 1; check in cycle 2.
//   Pattern p checks in cycle 2+p*(2+CHECK_GAP).
//   done is high in cycle 1+NUM_PATTERNS*(2+CHECK_GAP).
// - sig/rfr/pattern_idx hold their last values in IDLE after a run.
// - rst_n low mid-run: aborts immediately, all outputs 0, no done pulse.
// TESTING
// - LENGTH=4, N=8, GAP=2, start pulse -> 8 check pulses spaced 4 cycles;
//   sig=rfr=0..7; done at cycle 33; mismatch_cnt=0.
// - Same config, inject_err held 1 cycle during pattern 2's GAP ->
//   pattern 3 has sig=3, rfr=2; mismatch_cnt=1 at done.
// - GAP=0, N=4 -> check high in cycles 2,4,6,8; done in cycle 9;
//   start asserted mid-run is ignored.
// - LENGTH=1, N=3 -> sig sequence 0,1,0 (truncation);
//   inject_err every cycle -> mismatch_cnt=3.
// - N=300 with inject_err held high -> mismatch_cnt saturates at 255
//   (IDX_W=9, LENGTH=9).
// - rst_n asserted in the CHECK of pattern 5 -> all outputs 0 immediately,
//   no done; new start after release -> run restarts at pattern 0.

Source files
------------

// File: rtl/arr_check_sequencer.sv
// arr_check_sequencer: walks NUM_PATTERNS patterns onto sig/rfr, strobes check once per pattern and counts sig/rfr mismatches.
// Ports: clk, rst_n (async active-low); start begins a run from IDLE; inject_err corrupts rfr bit 0 of the next loaded pattern;
// sig/rfr pattern and reference to arr; check compare strobe; busy LOAD..GAP; done end-of-run pulse;
// pattern_idx index of the current pattern; mismatch_cnt saturating mismatch count for this run.
module arr_check_sequencer #(
  parameter int LENGTH       = 1,
  parameter int NUM_PATTERNS = 8,
  parameter int CHECK_GAP    = 2,
  parameter int IDX_W        = NUM_PATTERNS > 1 ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inject_err,
  output logic [LENGTH-1:0] sig,
  output logic [LENGTH-1:0] rfr,
  output logic              check,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  pattern_idx,
  output logic [7:0]        mismatch_cnt
);
  localparam int GW = CHECK_GAP > 1 ? $clog2(CHECK_GAP) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, CHK, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [GW-1:0] gap_cnt;
  logic err_pend, last_pat, pat_end, advance;
  logic [LENGTH-1:0] pat;
  assign last_pat = pattern_idx == IDX_W'(NUM_PATTERNS - 1);
  // a pattern ends in CHECK when there is no gap, otherwise in the final GAP cycle
  assign pat_end = state == CHK ? CHECK_GAP == 0 : state == GAP && gap_cnt == GW'(CHECK_GAP - 1);
  assign pat = LENGTH'(pattern_idx);
  assign advance = pat_end && !last_pat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    check = state == CHK;
    busy = state == LOAD || state == CHK || state == GAP;
    done = state == DONE;
    case (state)
      IDLE: state_nx = start ? LOAD : IDLE;
      LOAD: state_nx = CHK;
      CHK, GAP: state_nx = pat_end ? (last_pat ? DONE : LOAD) : state == CHK ? GAP : GAP;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sig <= '0;
      rfr <= '0;
      pattern_idx <= '0;
      mismatch_cnt <= '0;
      err_pend <= 1'b0;
      gap_cnt <= '0;
    end else begin
      // a request arriving on the LOAD edge is consumed directly, so the pending flag only clears there
      err_pend <= state == LOAD ? 1'b0 : err_pend | inject_err;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        pattern_idx <= '0;
        mismatch_cnt <= '0;
      end
      if (advance) pattern_idx <= pattern_idx + 1'b1;
      if (state == LOAD) begin
        sig <= pat;
        rfr <= pat ^ LENGTH'(err_pend | inject_err);
      end
      if (state == CHK && sig != rfr && mismatch_cnt != 8'hff) mismatch_cnt <= mismatch_cnt + 8'd1;
    end
endmodule

// File: tb/tb_arr_check_sequencer.sv
// tb_arr_check_sequencer: randomized scenarios on four configurations checked against a cycle-formula reference model.
module tb_arr_check_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic inject_err = 1'b0;
  int checks = 0;
  int failures = 0;
  bit inj [0:1023];
  logic [3:0] sig_a, rfr_a, sig_b, rfr_b;
  logic [0:0] sig_c, rfr_c;
  logic [8:0] sig_d, rfr_d, idx_d;
  logic [2:0] idx_a;
  logic [1:0] idx_b, idx_c;
  logic [7:0] mc_a, mc_b, mc_c, mc_d;
  logic ck_a, ck_b, ck_c, ck_d, bs_a, bs_b, bs_c, bs_d, dn_a, dn_b, dn_c, dn_d;
  logic [15:0] sg [4];
  logic [15:0] rf [4];
  logic [15:0] pi [4];
  logic [7:0] mc [4];
  logic ck [4];
  logic bs [4];
  logic dn [4];
  always #5 clk = ~clk;
  arr_check_sequencer #(.LENGTH(4), .NUM_PATTERNS(8), .CHECK_GAP(2)) u_a (.clk(clk), .rst_n(rst_n), .start(start),
    .inject_err(inject_err), .sig(sig_a), .rfr(rfr_a), .check(ck_a), .busy(bs_a), .done(dn_a), .pattern_idx(idx_a), .mismatch_cnt(mc_a));
  arr_check_sequencer #(.LENGTH(4), .NUM_PATTERNS(4), .CHECK_GAP(0)) u_b (.clk(clk), .rst_n(rst_n), .start(start),
    .inject_err(inject_err), .sig(sig_b), .rfr(rfr_b), .check(ck_b), .busy(bs_b), .done(dn_b), .pattern_idx(idx_b), .mismatch_cnt(mc_b));
  arr_check_sequencer #(.LENGTH(1), .NUM_PATTERNS(3), .CHECK_GAP(1)) u_c (.clk(clk), .rst_n(rst_n), .start(start),
    .inject_err(inject_err), .sig(sig_c), .rfr(rfr_c), .check(ck_c), .busy(bs_c), .done(dn_c), .pattern_idx(idx_c), .mismatch_cnt(mc_c));
  arr_check_sequencer #(.LENGTH(9), .NUM_PATTERNS(300), .CHECK_GAP(0)) u_d (.clk(clk), .rst_n(rst_n), .start(start),
    .inject_err(inject_err), .sig(sig_d), .rfr(rfr_d), .check(ck_d), .busy(bs_d), .done(dn_d), .pattern_idx(idx_d), .mismatch_cnt(mc_d));
  assign sg[0] = 16'(sig_a);
  assign sg[1] = 16'(sig_b);
  assign sg[2] = 16'(sig_c);
  assign sg[3] = 16'(sig_d);
  assign rf[0] = 16'(rfr_a);
  assign rf[1] = 16'(rfr_b);
  assign rf[2] = 16'(rfr_c);
  assign rf[3] = 16'(rfr_d);
  assign pi[0] = 16'(idx_a);
  assign pi[1] = 16'(idx_b);
  assign pi[2] = 16'(idx_c);
  assign pi[3] = 16'(idx_d);
  assign mc[0] = mc_a;
  assign mc[1] = mc_b;
  assign mc[2] = mc_c;
  assign mc[3] = mc_d;
  assign ck[0] = ck_a;
  assign ck[1] = ck_b;
  assign ck[2] = ck_c;
  assign ck[3] = ck_d;
  assign bs[0] = bs_a;
  assign bs[1] = bs_b;
  assign bs[2] = bs_c;
  assign bs[3] = bs_d;
  assign dn[0] = dn_a;
  assign dn[1] = dn_b;
  assign dn[2] = dn_c;
  assign dn[3] = dn_d;

  // mode 0: none, 1: random sparse, 2: every cycle, 3: single pulse in cycle arg
  task automatic fill(input int mode, input int arg);
    for (int i = 0; i < 1024; i++)
      inj[i] = mode == 0 ? 1'b0 : mode == 1 ? ($urandom % 4 == 0) : mode == 2 ? 1'b1 : (i == arg);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    inject_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Cycle c counts from the start cycle (c=0, start sampled on edge E0).
  // Pattern p occupies cycles 1+p*P .. P*(p+1) with P=2+gap: LOAD then CHECK then gap cycles; done at 1+n*P.
  // Pattern p is corrupted if any inject_err was sampled after the previous LOAD edge up to and including its own LOAD edge.
  task automatic run(input int sel, input int l, input int n, input int g, input bit pre, input bit mid,
                     input bit rst_first, input int abort_at);
    int per, t_done, errs, ph, p, es, nchk, lo, sat;
    bit corr [0:511];
    per = 2 + g;
    t_done = 1 + n * per;
    errs = 0;
    nchk = 0;
    for (int k = 0; k < n; k++) begin
      corr[k] = k == 0 && pre;
      lo = k == 0 ? 0 : 2 + (k - 1) * per;
      for (int c = lo; c <= 1 + k * per; c++) corr[k] = corr[k] | inj[c];
    end
    if (rst_first) apply_reset();
    for (int c = 0; c <= t_done + 1; c++) begin
      if (c > 0) begin
        ph = (c - 1) % per;
        p = (c - 1) / per;
        sat = errs > 255 ? 255 : errs;
        if (ck[sel]) nchk++;
        checks++;
        if (bs[sel] !== (c < t_done)) begin
          failures++;
          $display("FAIL busy inst=%0d cycle=%0d got=%b want=%b", sel, c, bs[sel], c < t_done);
        end
        checks++;
        if (ck[sel] !== (c < t_done && ph == 1)) begin
          failures++;
          $display("FAIL check inst=%0d cycle=%0d got=%b want=%b", sel, c, ck[sel], c < t_done && ph == 1);
        end
        checks++;
        if (dn[sel] !== (c == t_done)) begin
          failures++;
          $display("FAIL done inst=%0d cycle=%0d got=%b want=%b", sel, c, dn[sel], c == t_done);
        end
        if (c < t_done && ph == 1) begin
          es = p % (1 << l);
          checks++;
          if (sg[sel] !== 16'(es)) begin
            failures++;
            $display("FAIL sig inst=%0d pattern=%0d got=%0d want=%0d", sel, p, sg[sel], es);
          end
          checks++;
          if (rf[sel] !== 16'(es ^ int'(corr[p]))) begin
            failures++;
            $display("FAIL rfr inst=%0d pattern=%0d got=%0d want=%0d", sel, p, rf[sel], es ^ int'(corr[p]));
          end
          checks++;
          if (pi[sel] !== 16'(p)) begin
            failures++;
            $display("FAIL pattern_idx inst=%0d pattern=%0d got=%0d want=%0d", sel, p, pi[sel], p);
          end
          checks++;
          if (mc[sel] !== 8'(sat)) begin
            failures++;
            $display("FAIL mismatch_cnt inst=%0d pattern=%0d got=%0d want=%0d", sel, p, mc[sel], sat);
          end
          errs += int'(corr[p]);
        end
        if (c == t_done) begin
          checks++;
          if (mc[sel] !== 8'(sat)) begin
            failures++;
            $display("FAIL final_mismatch_cnt inst=%0d got=%0d want=%0d", sel, mc[sel], sat);
          end
        end
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        inject_err = 1'b0;
        #1;
        checks++;
        if ({ck[sel], bs[sel], dn[sel], sg[sel], rf[sel], pi[sel], mc[sel]} !== '0) begin
          failures++;
          $display("FAIL abort_outputs inst=%0d got sig=%0d rfr=%0d idx=%0d cnt=%0d ck=%b bs=%b dn=%b want all 0",
                   sel, sg[sel], rf[sel], pi[sel], mc[sel], ck[sel], bs[sel], dn[sel]);
        end
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (dn[sel] !== 1'b0 || bs[sel] !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done inst=%0d got done=%b busy=%b want 0 0", sel, dn[sel], bs[sel]);
          end
        end
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      start = c == 0 || (mid && (c == t_done / 2 || c == t_done));
      inject_err = inj[c];
      @(negedge clk);
    end
    start = 1'b0;
    inject_err = 1'b0;
    checks++;
    if (nchk != n) begin
      failures++;
      $display("FAIL check_pulses inst=%0d got=%0d want=%0d", sel, nchk, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ck[i], bs[i], dn[i], sg[i], rf[i], pi[i], mc[i]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got sig=%0d rfr=%0d idx=%0d cnt=%0d want all 0", i, sg[i], rf[i], pi[i], mc[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(0, 0);
    run(0, 4, 8, 2, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_inject_gap();
    fill(3, 11);
    run(0, 4, 8, 2, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_random_inject();
    repeat (3) begin
      fill(1, 0);
      run(0, 4, 8, 2, 1'b0, 1'b0, 1'b1, -1);
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) begin
      fill(1, 0);
      run(1, 4, 4, 0, 1'b0, 1'b1, 1'b1, -1);
    end
  endtask

  task automatic test_truncation();
    fill(2, 0);
    run(2, 1, 3, 1, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_saturation();
    fill(2, 0);
    run(3, 9, 300, 0, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_idle_carry();
    fill(0, 0);
    apply_reset();
    inject_err = 1'b1;
    @(negedge clk);
    inject_err = 1'b0;
    @(negedge clk);
    run(0, 4, 8, 2, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort();
    fill(0, 0);
    run(0, 4, 8, 2, 1'b0, 1'b0, 1'b1, 22);
    run(0, 4, 8, 2, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inject_gap();
    test_random_inject();
    test_back_to_back();
    test_truncation();
    test_saturation();
    test_idle_carry();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
